// File: rtl/mmio_out_fifo_if.sv
// Bundle of the port-A snoop bus and the consumer-side valid/ready stream
// for mmio_out_fifo. The master modport is the side that drives the write
// bus and consumes words; the slave modport is the FIFO itself.
// Optional macro OUT_LAST_HOLD_EN adds the held last-popped word (out_last).
interface mmio_out_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH_LOG2 = 2
);
  logic [ADDR_WIDTH-1:0]   addr_a;
  logic [DATA_WIDTH-1:0]   data_a;
  logic [DATA_WIDTH-1:0]   data_b;
  logic                    we_a;
  logic [2*DATA_WIDTH-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [DEPTH_LOG2:0]     count;
  logic                    full;
  logic                    empty;
  logic                    overflow;
`ifdef OUT_LAST_HOLD_EN
  logic [2*DATA_WIDTH-1:0] out_last;

  modport master (
    output addr_a, data_a, data_b, we_a, out_ready,
    input  out_data, out_valid, count, full, empty, overflow, out_last
  );

  modport slave (
    input  addr_a, data_a, data_b, we_a, out_ready,
    output out_data, out_valid, count, full, empty, overflow, out_last
  );
`else
  modport master (
    output addr_a, data_a, data_b, we_a, out_ready,
    input  out_data, out_valid, count, full, empty, overflow
  );

  modport slave (
    input  addr_a, data_a, data_b, we_a, out_ready,
    output out_data, out_valid, count, full, empty, overflow
  );
`endif
endinterface

// File: rtl/mmio_out_fifo.sv
// mmio_out_fifo: snoops port-A writes to OUT_ADDR, captures {data_a,data_b}
// into a small FIFO and hands the words to a consumer over valid/ready.
// Writes arriving while full (with no simultaneous pop) are dropped and
// flagged on the sticky overflow output.
// Optional macro OUT_LAST_HOLD_EN adds out_last, a register holding the most
// recently popped word for static displays.
module mmio_out_fifo #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] OUT_ADDR   = 'hF010,
  parameter int                    DEPTH_LOG2 = 2
) (
  input logic           clk,
  input logic           reset,
  mmio_out_fifo_if.slave bus
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam int                  WORD_W    = 2 * DATA_WIDTH;
  localparam logic [DEPTH_LOG2:0] COUNT_MAX = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WORD_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  overflow_q;

  logic                  push;
  logic                  pop;
  logic                  push_ok;
  logic                  full_w;
  logic                  empty_w;
  logic [WORD_W-1:0]     push_word;

  // A push that finds the FIFO full is still accepted when a pop frees the
  // head slot in the same cycle; pop is gated by empty so out_ready is
  // ignored while nothing is buffered.
  assign push      = bus.we_a && (bus.addr_a == OUT_ADDR);
  assign empty_w   = (count_q == '0);
  assign full_w    = (count_q == COUNT_MAX);
  assign pop       = !empty_w && bus.out_ready;
  assign push_ok   = push && (!full_w || pop);
  assign push_word = {bus.data_a, bus.data_b};

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push_ok) begin
        count_q <= count_q - 1'b1;
      end
      if (push && !push_ok) overflow_q <= 1'b1;
    end
  end

  // Word storage; contents are don't-care after reset because empty masks them.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  assign bus.out_data  = empty_w ? '0 : mem[rd_ptr];
  assign bus.out_valid = !empty_w;
  assign bus.count     = count_q;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.overflow  = overflow_q;

`ifdef OUT_LAST_HOLD_EN
  logic [WORD_W-1:0] last_q;

  // Hold the most recently consumed word so a static display keeps showing it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= '0;
    end else if (pop) begin
      last_q <= bus.out_data;
    end
  end

  assign bus.out_last = last_q;
`endif

endmodule

// File: tb/tb_mmio_out_fifo.sv
// Testbench for mmio_out_fifo: table of single-cycle vectors with expected
// occupancy/overflow, a scoreboard queue for word ordering, and hand-written
// sequences for full push+pop, streaming wrap and asynchronous reset.
`timescale 1ns/1ps
module tb_mmio_out_fifo;

  localparam int          DW       = 8;
  localparam int          AW       = 16;
  localparam int          DL2      = 2;
  localparam int          DEPTH    = 4;
  localparam logic [15:0] OUT_ADDR = 16'hF010;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] sb [$];

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  da;
    logic [7:0]  db;
    logic        we;
    logic        ready;
    int          exp_count;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [14];

  mmio_out_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL2)) bus ();

  mmio_out_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .OUT_ADDR  (OUT_ADDR),
    .DEPTH_LOG2(DL2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of bus activity; a consumer pop is checked against the
  // scoreboard head before the edge, and an accepted push is queued.
  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] da,
                               input logic [7:0] db, input logic we, input logic ready);
    int   was;
    logic popped;
    logic [15:0] head;
    @(negedge clk);
    bus.addr_a    = addr;
    bus.data_a    = da;
    bus.data_b    = db;
    bus.we_a      = we;
    bus.out_ready = ready;
    was    = sb.size();
    popped = 1'b0;
    if (ready && was > 0) begin
      head = sb.pop_front();
      compare("pop_valid", {31'b0, bus.out_valid}, 32'd1);
      compare("pop_data", {16'b0, bus.out_data}, {16'b0, head});
      popped = 1'b1;
    end
    if (we && addr == OUT_ADDR && (was < DEPTH || popped)) sb.push_back({da, db});
    @(posedge clk);
    #1;
    bus.we_a      = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic checkOutput(input int exp_count, input logic exp_ovf, input string tag);
    compare({tag, ".count"},    {29'b0, bus.count},     exp_count);
    compare({tag, ".valid"},    {31'b0, bus.out_valid}, {31'b0, exp_count != 0});
    compare({tag, ".full"},     {31'b0, bus.full},      {31'b0, exp_count == DEPTH});
    compare({tag, ".empty"},    {31'b0, bus.empty},     {31'b0, exp_count == 0});
    compare({tag, ".overflow"}, {31'b0, bus.overflow},  {31'b0, exp_ovf});
  endtask

  initial begin
    vecs[0]  = '{16'hF010, 8'h12, 8'h34, 1'b1, 1'b0, 1, 1'b0};
    vecs[1]  = '{16'h0000, 8'h00, 8'h00, 1'b0, 1'b1, 0, 1'b0};
    vecs[2]  = '{16'hF010, 8'h00, 8'h01, 1'b1, 1'b0, 1, 1'b0};
    vecs[3]  = '{16'hF010, 8'h00, 8'h02, 1'b1, 1'b0, 2, 1'b0};
    vecs[4]  = '{16'hF010, 8'h00, 8'h03, 1'b1, 1'b0, 3, 1'b0};
    vecs[5]  = '{16'hF010, 8'h00, 8'h04, 1'b1, 1'b0, 4, 1'b0};
    vecs[6]  = '{16'hF010, 8'h00, 8'h05, 1'b1, 1'b0, 4, 1'b1};
    vecs[7]  = '{16'h0000, 8'h00, 8'h00, 1'b0, 1'b1, 3, 1'b1};
    vecs[8]  = '{16'h0000, 8'h00, 8'h00, 1'b0, 1'b1, 2, 1'b1};
    vecs[9]  = '{16'h0000, 8'h00, 8'h00, 1'b0, 1'b1, 1, 1'b1};
    vecs[10] = '{16'h0000, 8'h00, 8'h00, 1'b0, 1'b1, 0, 1'b1};
    vecs[11] = '{16'hF011, 8'hAA, 8'h55, 1'b1, 1'b0, 0, 1'b1};
    vecs[12] = '{16'hFFFE, 8'hAA, 8'h55, 1'b1, 1'b1, 0, 1'b1};
    vecs[13] = '{16'hF010, 8'hAA, 8'h55, 1'b0, 1'b1, 0, 1'b1};

    bus.addr_a    = '0;
    bus.data_a    = '0;
    bus.data_b    = '0;
    bus.we_a      = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput(0, 1'b0, "reset");
    compare("reset.data", {16'b0, bus.out_data}, 32'h0);
    reset = 1'b1;

    $display("[TB] vector table: single write, overflow fill/drain, non-matching writes");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].da, vecs[i].db, vecs[i].we, vecs[i].ready);
      checkOutput(vecs[i].exp_count, vecs[i].exp_ovf, $sformatf("vec%0d", i));
    end
    compare("empty.data", {16'b0, bus.out_data}, 32'h0);

    $display("[TB] full FIFO with simultaneous push and pop");
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    sb.delete();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(OUT_ADDR, 8'hAA, 8'(8'hA0 + k), 1'b1, 1'b0);
    end
    checkOutput(4, 1'b0, "t4_full");
    applyStimulus(OUT_ADDR, 8'hBE, 8'hEF, 1'b1, 1'b1);
    checkOutput(4, 1'b0, "t4_pushpop");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(16'h0000, 8'h00, 8'h00, 1'b0, 1'b1);
      checkOutput(3 - k, 1'b0, $sformatf("t4_drain%0d", k));
    end

    $display("[TB] streaming push/pop with pointer wrap");
    for (int k = 0; k < 10; k++) begin
      applyStimulus(OUT_ADDR, 8'hC0, 8'(k), 1'b1, 1'b1);
      checkOutput(1, 1'b0, $sformatf("t6_stream%0d", k));
    end
    applyStimulus(16'h0000, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput(0, 1'b0, "t6_done");
`ifdef OUT_LAST_HOLD_EN
    compare("t6_out_last", {16'b0, bus.out_last}, 32'h0000_C009);
    applyStimulus(16'h0000, 8'h00, 8'h00, 1'b0, 1'b1);
    compare("t6_out_last_hold", {16'b0, bus.out_last}, 32'h0000_C009);
`endif

    $display("[TB] asynchronous reset with words buffered");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(OUT_ADDR, 8'h70, 8'(k), 1'b1, 1'b0);
    end
    checkOutput(4, 1'b1, "t1_overfill");
    applyStimulus(16'h0000, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput(3, 1'b1, "t1_three");
    @(negedge clk);
    reset = 1'b0;
    #2;
    checkOutput(0, 1'b0, "t1_async");
    compare("t1_async.data", {16'b0, bus.out_data}, 32'h0);
`ifdef OUT_LAST_HOLD_EN
    compare("t1_async.out_last", {16'b0, bus.out_last}, 32'h0);
`endif
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(16'h0000, 8'h00, 8'h00, 1'b0, 1'b1);
    checkOutput(0, 1'b0, "t1_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
